// File: rtl/pipelined_add_sub.sv
// Pipelined ALU slice for ADD / SUB / SLT / SLTU.
// The XLEN-bit adder is cut into STAGES equal slices. Each stage resolves one
// slice with a flat carry-lookahead network fed by the carry registered from
// the previous stage. The final stage's register is the output register.
//
// Handshake: an operand set is accepted on a rising edge when
// In_Valid && In_Ready; a result is consumed on a rising edge when
// Out_Valid && Out_Ready. The pipe stalls (everything holds, no bubble
// compaction) while Out_Valid && !Out_Ready, and In_Ready is the
// combinational inverse of that stall condition.
//
// Legal STAGES values are 1, 2 and 4, with XLEN divisible by STAGES.
module pipelined_add_sub #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    input  logic [1:0]      Op,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [XLEN-1:0] Result,
    output logic            Overflow,
    output logic            Carry_Out,
    output logic            Zero
);

    localparam int W = XLEN / STAGES;   // slice width
    localparam int L = STAGES - 1;      // index of the last stage

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // One W-bit carry-lookahead slice. Every carry is a flat sum of products
    // of generate/propagate terms and the slice carry-in.
    // Returns {carry out, carry into the slice MSB, sum}.
    function automatic logic [W+1:0] cla_slice(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic         cin);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         term;
        logic         pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & cin);
        end
        return {c[W], c[W-1], p ^ c[W-1:0]};
    endfunction

    // Stage registers: index k holds what stage k produced.
    logic            v_q  [STAGES];
    logic [XLEN-1:0] a_q  [STAGES];
    logic [XLEN-1:0] b_q  [STAGES];
    logic [XLEN-1:0] s_q  [STAGES];
    logic            c_q  [STAGES];
    logic [1:0]      op_q [STAGES];

    // Next values entering each stage register.
    logic            v_n     [STAGES];
    logic [XLEN-1:0] a_n     [STAGES];
    logic [XLEN-1:0] b_n     [STAGES];
    logic [XLEN-1:0] s_n     [STAGES];
    logic            c_n     [STAGES];
    logic [1:0]      op_n    [STAGES];
    logic            cin_n   [STAGES];
    logic [W+1:0]    slice_n [STAGES];
    logic            msb_c;

    logic            stall;
    logic [XLEN-1:0] res_n;
    logic            ovf_n;
    logic            v_add;

    assign Out_Valid = v_q[L];
    assign stall     = Out_Valid & ~Out_Ready;
    assign In_Ready  = ~stall;

    // Per-stage datapath: pick stage inputs, then resolve slice k in stage k.
    always_comb begin
        // Stage 0 takes the ports; B is inverted with carry-in 1 for SUB/SLT/SLTU.
        v_n[0]   = In_Valid;
        op_n[0]  = Op;
        a_n[0]   = Rs1;
        b_n[0]   = (Op == OP_ADD) ? Rs2 : ~Rs2;
        s_n[0]   = '0;
        cin_n[0] = (Op != OP_ADD);
        for (int k = 1; k < STAGES; k++) begin
            v_n[k]   = v_q[k-1];
            op_n[k]  = op_q[k-1];
            a_n[k]   = a_q[k-1];
            b_n[k]   = b_q[k-1];
            s_n[k]   = s_q[k-1];
            cin_n[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_n[k]           = cla_slice(a_n[k][k*W +: W], b_n[k][k*W +: W], cin_n[k]);
            s_n[k][k*W +: W]     = slice_n[k][W-1:0];
            c_n[k]               = slice_n[k][W+1];
        end
        msb_c = slice_n[L][W];
    end

    // Final result selection from the fully resolved sum of the last stage.
    always_comb begin
        res_n = '0;
        ovf_n = 1'b0;
        v_add = c_n[L] ^ msb_c;
        case (op_n[L])
            OP_ADD, OP_SUB: begin
                res_n = s_n[L];
                ovf_n = v_add;
            end
            OP_SLT: begin
                res_n = {{(XLEN-1){1'b0}}, s_n[L][XLEN-1] ^ v_add};
            end
            OP_SLTU: begin
                res_n = {{(XLEN-1){1'b0}}, ~c_n[L]};
            end
            default: begin
                res_n = '0;
            end
        endcase
    end

    // Valid bits: cleared by reset, frozen during a stall.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= v_n[k];
        end
    end

    // Operand/partial-sum registers travel with the valid bits; frozen during a stall.
    always_ff @(posedge CLK) begin
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_n[k];
                b_q[k]  <= b_n[k];
                s_q[k]  <= s_n[k];
                c_q[k]  <= c_n[k];
                op_q[k] <= op_n[k];
            end
        end
    end

    // Output register: loads only a valid result, otherwise holds its last value.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            Result    <= '0;
            Overflow  <= 1'b0;
            Carry_Out <= 1'b0;
            Zero      <= 1'b0;
        end else if (!stall && v_n[L]) begin
            Result    <= res_n;
            Overflow  <= ovf_n;
            Carry_Out <= c_n[L];
            Zero      <= (res_n == '0);
        end
    end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2: pipeline depth; legal values are 1, 2 and 4, and XLEN mod STAGES SHALL equal 0.
REQ-003 Port CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port In_Valid  input  1  means the operand set is valid.
REQ-006 Port In_Ready  output  1  means the block can accept an operand set this cycle.
REQ-007 Port Rs1  input  XLEN  is operand A.
REQ-008 Port Rs2  input  XLEN  is operand B.
REQ-009 Port Op  input  2  selects the operation: 00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
REQ-010 Port Out_Valid  output  1  means the result and flags are valid.
REQ-011 Port Out_Ready  input  1  means the consumer accepts the result this cycle.
REQ-012 Port Result  output  XLEN  is the operation result.
REQ-013 Port Overflow  output  1  is the signed overflow flag.
REQ-014 Port Carry_Out  output  1  is the raw carry out of bit XLEN-1.
REQ-015 Port Zero  output  1  means Result equals 0.

Function
REQ-016 Datapath: the B operand SHALL be ~Rs2 with carry-in 1 for Op in {SUB, SLT, SLTU}, and Rs2 with carry-in 0 for ADD.
REQ-017 The adder SHALL be split into STAGES slices of XLEN/STAGES bits each.
REQ-018 Slice k SHALL be computed by carry-lookahead in stage k, using the carry registered from stage k-1.
REQ-019 Untouched operand bits and Op SHALL travel with each stage's valid bit.
REQ-020 Latency: an operand set accepted at edge N SHALL present Out_Valid=1 after edge N+STAGES-1, given no stall.
REQ-021 Throughput SHALL be one operation per cycle with no stall.
REQ-022 Acceptance SHALL occur when In_Valid=1 and In_Ready=1 at a rising edge.
REQ-023 Stall is defined as Out_Valid=1 and Out_Ready=0.
REQ-024 In_Ready SHALL equal NOT stall, combinationally.
REQ-025 During a stall, all stage registers, valid bits and outputs SHALL hold; there is no bubble compaction.
REQ-026 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-027 A result SHALL be consumed when Out_Valid=1 and Out_Ready=1.
REQ-028 If In_Valid=0 and the pipe is not stalled, a bubble (valid=0) SHALL enter stage 1.
REQ-029 For ADD/SUB, Result SHALL be the XLEN-bit sum modulo 2^XLEN.
REQ-030 For ADD/SUB, Overflow SHALL equal carry[XLEN] XOR carry[XLEN-1].
REQ-031 For SLT, Result SHALL be {0..0, sum[XLEN-1] XOR V}, where V is the subtract overflow; Overflow SHALL be 0.
REQ-032 For SLTU, Result SHALL be {0..0, NOT Carry_Out}; Overflow SHALL be 0.
REQ-033 Carry_Out SHALL be reported for all Op values.
REQ-034 Zero SHALL be computed on the final Result.
REQ-035 When Out_Valid=0, Result and all flags SHALL hold their last values.
REQ-036 Boundary: Rs1=Rs2=0 with SUB SHALL give Result 0, Zero 1 and Carry_Out 1.
REQ-037 Boundary: the carry into bit XLEN-1 SHALL be correct across slice boundaries for every STAGES value.

Reset
REQ-038 While rst_n=0 at a rising edge, all stage valid bits SHALL be cleared.
REQ-039 While rst_n=0 at a rising edge, Out_Valid, Result, Overflow, Carry_Out and Zero SHALL be set to 0.
REQ-040 Because Out_Valid=0 during reset, In_Ready SHALL be 1 during reset.
REQ-041 Operations in flight when reset is asserted SHALL be discarded and SHALL never appear at the output.
REQ-042 Acceptance SHALL be ignored in any cycle where rst_n=0.

Verification
REQ-043 Scenario (XLEN=32, STAGES=2): ADD 0x7FFFFFFF+0x00000001, accepted at edge N -> Out_Valid after edge N+1; Result 0x80000000, Overflow 1, Carry_Out 0, Zero 0.
REQ-044 Scenario: SUB 5-5 -> Result 0, Zero 1, Carry_Out 1, Overflow 0.
REQ-045 Scenario: SUB 0x00000000-0x00000001 -> Result 0xFFFFFFFF, Carry_Out 0, Overflow 0.
REQ-046 Scenario: SLT Rs1=0xFFFFFFFF, Rs2=1 -> Result 1; SLTU on the same operands -> Result 0.
REQ-047 Scenario: 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4), then Out_Ready=0 for 3 cycles after the first result -> In_Ready=0 for those cycles, outputs held, results 2, 4, 6, 8 in order with no duplication.
REQ-048 Scenario: rst_n=0 for one edge with 2 operations in flight -> Out_Valid=0 next cycle; neither result emerges after release; a new ADD 1+1 returns 2 at normal latency.
REQ-049 Scenario: STAGES in {1, 2, 4}, 10k random Op/Rs1/Rs2 with random Out_Ready -> every output matches the reference model, latency equals STAGES, and no drops occur.
